mcdf_chnl_arbiter: RTL

- Arbitrates among NCH channel slave buffers of the multi-channel data formatter and sequences one packet at a time into the formatter.
- Selects a winner by configured priority, with round-robin tie-break, then requests the formatter and waits for its grant.
- Streams exactly one packet of the configured length from the winning channel, popping that channel's buffer word by word.

---
 rtl/mcdf_chnl_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mcdf_chnl_arbiter.sv
// Channel arbiter for the multi-channel data formatter.
// Picks one requesting channel by priority (round-robin among equals),
// requests the formatter, then streams one packet from that channel.

// Per-channel arbitration key: {priority, round-robin distance}; lower wins.
module mcdf_chnl_arb_lane #(
    parameter int NCH = 3,
    parameter int CHW = 2,
    parameter int IDX = 0
) (
    input  logic             req_i,
    input  logic [1:0]       prio_i,
    input  logic [CHW-1:0]   rr_last_i,
    output logic             vld_o,
    output logic [CHW+1:0]   key_o
);
    localparam logic [CHW:0] IDX_W = IDX[CHW:0];
    localparam logic [CHW:0] NCH_W = NCH[CHW:0];
    localparam logic [CHW:0] ONE   = {{CHW{1'b0}}, 1'b1};

    logic [CHW:0] rr_ext;
    logic [CHW:0] dist_full;

    assign rr_ext = {1'b0, rr_last_i};

    // Distance from the channel after rr_last, scanning upward modulo NCH.
    always_comb begin
        if (IDX_W > rr_ext) dist_full = IDX_W - rr_ext - ONE;
        else                dist_full = IDX_W + NCH_W - rr_ext - ONE;
    end

    assign vld_o = req_i;
    assign key_o = {prio_i, dist_full[CHW-1:0]};
endmodule

module mcdf_chnl_arbiter #(
    parameter int NCH = 3,
    parameter int DW  = 8,
    parameter int CHW = 2
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [NCH-1:0]    slv_req_i,
    input  logic [2*NCH-1:0]  slv_prio_i,
    input  logic [2*NCH-1:0]  slv_len_i,
    input  logic [NCH-1:0]    slv_val_i,
    input  logic [DW*NCH-1:0] slv_data_i,
    output logic [NCH-1:0]    slv_ack_o,
    output logic              fmt_req_o,
    output logic [CHW-1:0]    fmt_chid_o,
    output logic [5:0]        fmt_length_o,
    input  logic              fmt_grant_i,
    output logic              fmt_send_o,
    output logic [DW-1:0]     fmt_data_o,
    output logic              fmt_end_o
);
    typedef enum logic [1:0] {IDLE, REQ, SEND} state_e;

    localparam logic [CHW-1:0] RR_RST = CHW'(NCH - 1);

    state_e              state_q;
    logic [CHW-1:0]      rr_last_q;
    logic [CHW-1:0]      chid_q;
    logic [5:0]          len_q;
    logic                req_q;
    logic [4:0]          cnt_q;
    logic [4:0]          cnt_d;

    logic [NCH-1:0]           lane_vld;
    logic [NCH-1:0][CHW+1:0]  lane_key;

    logic                best_vld;
    logic [CHW+1:0]      best_key;
    logic [CHW-1:0]      best_id;
    logic [1:0]          best_len;

    logic                sel_val;
    logic [DW-1:0]       sel_data;
    logic                send_w;
    logic                end_w;

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_lane
            mcdf_chnl_arb_lane #(.NCH(NCH), .CHW(CHW), .IDX(g)) u_lane (
                .req_i     (slv_req_i[g]),
                .prio_i    (slv_prio_i[2*g +: 2]),
                .rr_last_i (rr_last_q),
                .vld_o     (lane_vld[g]),
                .key_o     (lane_key[g])
            );
        end
    endgenerate

    // Minimum-key search over requesting channels; keys are unique.
    always_comb begin
        best_vld = 1'b0;
        best_key = '1;
        best_id  = '0;
        best_len = '0;
        for (int i = 0; i < NCH; i++) begin
            if (lane_vld[i] && (!best_vld || lane_key[i] < best_key)) begin
                best_vld = 1'b1;
                best_key = lane_key[i];
                best_id  = CHW'(i);
                best_len = slv_len_i[2*i +: 2];
            end
        end
    end

    // Combinational path from the granted slave head word to the formatter.
    always_comb begin
        sel_val  = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (chid_q == CHW'(i)) begin
                sel_val  = slv_val_i[i];
                sel_data = slv_data_i[DW*i +: DW];
            end
        end
        send_w = (state_q == SEND) && sel_val;
        end_w  = send_w && ({1'b0, cnt_q} == (len_q - 6'd1));
        cnt_d  = cnt_q + 5'd1;
    end

    // One-hot pop strobe back to the channel being drained.
    always_comb begin
        slv_ack_o = '0;
        for (int i = 0; i < NCH; i++) begin
            slv_ack_o[i] = send_w && (chid_q == CHW'(i));
        end
    end

    assign fmt_send_o   = send_w;
    assign fmt_data_o   = send_w ? sel_data : '0;
    assign fmt_end_o    = end_w;
    assign fmt_req_o    = req_q;
    assign fmt_chid_o   = chid_q;
    assign fmt_length_o = len_q;

    // Packet sequencer: arbitrate, request the formatter, stream one packet.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            rr_last_q <= RR_RST;
            chid_q    <= '0;
            len_q     <= '0;
            req_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (best_vld) begin
                        chid_q  <= best_id;
                        len_q   <= 6'd4 << best_len;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (fmt_grant_i) begin
                        req_q   <= 1'b0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (send_w) begin
                        if (end_w) begin
                            cnt_q     <= '0;
                            rr_last_q <= chid_q;
                            state_q   <= IDLE;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
